store_buffer_unit: RTL and testbench
====================================

Name: store_buffer_unit

Overview:
Parametrised successor to the MEM-stage store data formatter. Accepts sw/sh/sb (and sd when 64-bit) store requests from the MEM stage and lane-aligns data to the byte offset with per-byte enables. Rejects misaligned stores and queues formatted stores in a DEPTH-entry FIFO that drains to data memory over a valid/ready handshake. Sits between the MEM pipeline register and the data-memory write port.

Parameters:
DATA_W, 32, memory data width in bits; 32 or 64 only; NB = DATA_W/8 byte lanes
ADDR_W, 32, byte-address width
DEPTH, 4, store FIFO entries; power of two, >= 2

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
st_valid  input  1  MEM stage presents a store this cycle
st_ready  output  1  buffer can accept; equals !full
st_addr  input  ADDR_W  store byte address
st_data  input  DATA_W  source register value (RT), data in low bits
st_sel  input  2  00 word, 01 half, 10 byte, 11 doubleword (DATA_W=64) / word (DATA_W=32)
misalign  output  1  registered one-cycle pulse: last offered store was misaligned and dropped
mem_valid  output  1  FIFO head valid
mem_ready  input  1  memory accepts head
mem_addr  output  ADDR_W  head address with low log2(NB) bits zeroed
mem_wdata  output  DATA_W  lane-aligned write data
mem_be  output  NB  byte enables, bit i = lane i
count  output  log2(DEPTH)+1  entries held
ld_addr  input  ADDR_W  load address for hazard check (STORE_FWD_EN)
ld_hazard  output  1  pending store overlaps load word (STORE_FWD_EN)

Behaviour:
- Reset (Rst_n low, async): FIFO emptied, pointers 0, count 0, mem_valid 0, misalign 0, mem_addr/mem_wdata/mem_be 0; st_ready 1 after reset. Reset mid-drain discards all pending stores; no partial write is retried.
- Off = st_addr[log2(NB)-1:0]. Little-endian lanes: byte lane i = bits [8i+7:8i].
- Formatting: byte -> st_data[7:0] replicated to all lanes, be = 1<<Off. Half -> st_data[15:0] replicated, be = 2'b11<<Off. Word -> st_data[31:0] replicated, be = 4'hF<<Off. Doubleword (64 only) -> full data, be all ones. Unwritten lanes carry replicated data; be is authoritative.
- Alignment: half needs Off[0]=0; word needs Off[1:0]=0; dword needs Off=0; byte always aligned. Misaligned store with st_valid & st_ready: not enqueued, misalign=1 the next cycle for exactly one cycle.
- Enqueue on st_valid & st_ready & aligned at rising edge. Dequeue on mem_valid & mem_ready. Simultaneous enqueue and dequeue: count unchanged, both pointers advance. No bypass: store accepted in cycle N appears on mem_* at earliest cycle N+1.
- Full (count==DEPTH): st_ready=0, st_valid ignored, no misalign check. Empty: mem_valid=0, mem_* hold last values.
- Pointers wrap modulo DEPTH; count distinguishes full/empty.
- mem_addr/mem_wdata/mem_be stable while mem_valid & !mem_ready. Stores drain in program order.
- Throughput: one enqueue and one dequeue per cycle sustained.

Optional Feature:
STORE_FWD_EN: when defined, ld_hazard is combinational = OR over valid entries of (entry word address == ld_addr word address, low log2(NB) bits ignored); MEM/hazard unit stalls loads on it. Includes an incoming store being enqueued the same cycle only once it is registered. When undefined, ld_hazard tied 0, ld_addr unused, no comparators built; ports remain.

Test Plan:
- DATA_W=32: sb addr 0x1003 data 0x000000AB, mem_ready=1 -> next cycle mem_valid=1, mem_addr 0x1000, mem_be 4'b1000, mem_wdata[31:24]=0xAB.
- sh addr 0x2002 data 0x1234 -> mem_be 4'b1100, mem_wdata[31:16]=0x1234; sh addr 0x2001 -> no enqueue, misalign=1 one cycle, count stays 0.
- mem_ready=0, offer 5 aligned sw (DEPTH=4) -> 4 accepted, st_ready=0 at count 4, 5th held; release mem_ready -> data drains in order, 5th accepted after first dequeue.
- Full with simultaneous mem_ready=1 and st_valid=1 -> st_ready=0 that cycle, count 4->3, next cycle enqueue accepted, count back to 4.
- Rst_n low for 1 cycle with 3 entries pending -> mem_valid=0, count=0 immediately, no further mem writes.
- STORE_FWD_EN, pending sw at 0x3000: ld_addr 0x3002 -> ld_hazard=1; ld_addr 0x3004 -> 0; after drain -> 0. Undefined: always 0.

Source files
------------

// File: rtl/store_buffer_unit.sv
// store_buffer_unit: formats MEM-stage stores (sb/sh/sw, sd when DATA_W=64)
// into lane-aligned data with byte enables, drops misaligned stores, and
// queues formatted stores in a DEPTH-entry FIFO drained over valid/ready.
// Optional macro STORE_FWD_EN builds the load/store word-overlap detector
// driving ld_hazard; without it ld_hazard is tied low.
module store_buffer_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [DATA_W-1:0]         st_data,
  input  logic [1:0]                st_sel,
  output logic                      misalign,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W/8-1:0]       mem_be,
  output logic [$clog2(DEPTH):0]    count,
  input  logic [ADDR_W-1:0]         ld_addr,
  output logic                      ld_hazard
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [NB-1:0]     be_mem   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_data_q;
  logic [NB-1:0]     last_be_q;

  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] fmt_data;
  logic [NB-1:0]     fmt_be;
  logic              aligned;
  logic              offer, enq, deq;

  assign off       = st_addr[OFF_W-1:0];
  assign st_ready  = (count_q != FULL_CNT);
  assign mem_valid = (count_q != '0);
  assign offer     = st_valid & st_ready;
  assign enq       = offer & aligned;
  assign deq       = mem_valid & mem_ready;
  assign count     = count_q;
  assign misalign  = misalign_q;

  // Lane formatting: replicate the source datum across lanes, enables select the target bytes
  always_comb begin
    fmt_data = {(NB/4){st_data[31:0]}};
    fmt_be   = NB'(4'hF) << off;
    aligned  = (off[1:0] == 2'b00);
    case (st_sel)
      2'b10: begin
        fmt_data = {NB{st_data[7:0]}};
        fmt_be   = NB'(1) << off;
        aligned  = 1'b1;
      end
      2'b01: begin
        fmt_data = {(NB/2){st_data[15:0]}};
        fmt_be   = NB'(3) << off;
        aligned  = ~off[0];
      end
      2'b11: begin
        if (DATA_W == 64) begin
          fmt_data = st_data;
          fmt_be   = '1;
          aligned  = (off == '0);
        end
      end
      default: ;
    endcase
  end

  // Next-state for pointers, occupancy and the misalign pulse
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = offer & ~aligned;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Control state; async reset discards all pending stores
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // FIFO storage; contents are only meaningful under count, so no reset needed
  always_ff @(posedge Clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      data_mem[wr_ptr_q] <= fmt_data;
      be_mem[wr_ptr_q]   <= fmt_be;
    end
  end

  // Remember the most recently dequeued head so mem_* hold while empty
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_addr_q <= '0;
      last_data_q <= '0;
      last_be_q   <= '0;
    end else if (deq) begin
      last_addr_q <= addr_mem[rd_ptr_q];
      last_data_q <= data_mem[rd_ptr_q];
      last_be_q   <= be_mem[rd_ptr_q];
    end
  end

  // Head presentation: live FIFO head when valid, otherwise the last value written
  always_comb begin
    mem_addr  = last_addr_q;
    mem_wdata = last_data_q;
    mem_be    = last_be_q;
    if (mem_valid) begin
      mem_addr  = addr_mem[rd_ptr_q];
      mem_wdata = data_mem[rd_ptr_q];
      mem_be    = be_mem[rd_ptr_q];
    end
  end

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] rel;

  // Word-address overlap of the load against every occupied entry
  always_comb begin
    ld_hazard = 1'b0;
    rel       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, rel} < count_q) &&
          (addr_mem[i][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W]))
        ld_hazard = 1'b1;
    end
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hazard      = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer_unit.sv
module tb_store_buffer_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_sel;
  logic        misalign;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  count;
  logic [31:0] ld_addr;
  logic        ld_hazard;

  int errors = 0;
  int checks = 0;
  logic hz_exp;

  store_buffer_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_sel(st_sel),
    .misalign(misalign),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .count(count),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_sel   = s;
  endtask

  initial begin
    Rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_sel = 2'b00;
    mem_ready = 1'b0; ld_addr = '0;
`ifdef STORE_FWD_EN
    hz_exp = 1'b1;
`else
    hz_exp = 1'b0;
`endif
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    Rst_n = 1'b1;
    tick();

    // sb at offset 3, no bypass into mem_* in the same cycle
    offer(32'h0000_1003, 32'h0000_00AB, 2'b10);
    mem_ready = 1'b1;
    #1;
    chk("sb_no_bypass", 64'(mem_valid), 64'd0);
    tick();
    chk("sb_valid", 64'(mem_valid), 64'd1);
    chk("sb_addr", 64'(mem_addr), 64'h1000);
    chk("sb_be", 64'(mem_be), 64'b1000);
    chk("sb_wdata", 64'(mem_wdata), 64'hABAB_ABAB);
    chk("sb_misalign", 64'(misalign), 64'd0);
    // simultaneous enqueue and dequeue keeps count at 1
    offer(32'h0000_1000, 32'h0000_00CD, 2'b10);
    tick();
    chk("encdeq_count", 64'(count), 64'd1);
    chk("encdeq_be", 64'(mem_be), 64'b0001);
    chk("encdeq_wdata", 64'(mem_wdata), 64'hCDCD_CDCD);
    st_valid = 1'b0;
    tick();
    chk("empty_valid", 64'(mem_valid), 64'd0);
    chk("empty_hold_be", 64'(mem_be), 64'b0001);
    chk("empty_hold_addr", 64'(mem_addr), 64'h1000);

    // sh aligned at offset 2
    mem_ready = 1'b0;
    offer(32'h0000_2002, 32'h0000_1234, 2'b01);
    tick();
    st_valid = 1'b0;
    chk("sh_be", 64'(mem_be), 64'b1100);
    chk("sh_wdata", 64'(mem_wdata), 64'h1234_1234);
    chk("sh_addr", 64'(mem_addr), 64'h2000);
    mem_ready = 1'b1;
    tick();
    chk("sh_drained", 64'(count), 64'd0);
    // sh misaligned: dropped, one-cycle misalign pulse
    offer(32'h0000_2001, 32'h0000_5678, 2'b01);
    tick();
    st_valid = 1'b0;
    chk("sh_mis_pulse", 64'(misalign), 64'd1);
    chk("sh_mis_count", 64'(count), 64'd0);
    chk("sh_mis_valid", 64'(mem_valid), 64'd0);
    tick();
    chk("sh_mis_clear", 64'(misalign), 64'd0);
    // sw misaligned at offset 2
    offer(32'h0000_4002, 32'h1111_2222, 2'b00);
    tick();
    st_valid = 1'b0;
    chk("sw_mis_pulse", 64'(misalign), 64'd1);
    chk("sw_mis_count", 64'(count), 64'd0);

    // fill to full with mem_ready low
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k), 2'b00);
      #1;
      chk("fill_ready", 64'(st_ready), 64'd1);
      tick();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(st_ready), 64'd0);
    offer(32'h0000_0110, 32'hA000_0004, 2'b01 ^ 2'b01);
    tick();
    chk("full_hold_count", 64'(count), 64'd4);
    chk("full_head_addr", 64'(mem_addr), 64'h100);
    chk("full_head_wdata", 64'(mem_wdata), 64'hA000_0000);
    chk("full_head_be", 64'(mem_be), 64'hF);
    mem_ready = 1'b1;
    #1;
    chk("full_deq_ready", 64'(st_ready), 64'd0);
    tick();
    chk("deq_count", 64'(count), 64'd3);
    chk("deq_ready", 64'(st_ready), 64'd1);
    chk("deq_head", 64'(mem_wdata), 64'hA000_0001);
    mem_ready = 1'b0;
    tick();
    st_valid = 1'b0;
    chk("refill_count", 64'(count), 64'd4);
    chk("stall_stable", 64'(mem_wdata), 64'hA000_0001);
    mem_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("drain_wdata", 64'(mem_wdata), 64'(32'hA000_0000 + 32'(k)));
      chk("drain_addr", 64'(mem_addr), 64'(32'h100 + 32'(4 * k)));
      tick();
    end
    chk("drain_done", 64'(count), 64'd0);
    chk("drain_valid", 64'(mem_valid), 64'd0);

    // reset while three stores pending
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(32'h200 + 32'(4 * k), 32'hB000_0000 + 32'(k), 2'b00);
      tick();
    end
    st_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd3);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(mem_valid), 64'd0);
    tick();
    Rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 64'(mem_valid), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);

    // load hazard against a pending word store
    mem_ready = 1'b0;
    offer(32'h0000_3000, 32'hCAFE_F00D, 2'b00);
    ld_addr = 32'h0000_3000;
    #1;
    chk("hz_unregistered", 64'(ld_hazard), 64'd0);
    tick();
    st_valid = 1'b0;
    ld_addr = 32'h0000_3002;
    #1;
    chk("hz_same_word", 64'(ld_hazard), 64'(hz_exp));
    ld_addr = 32'h0000_3004;
    #1;
    chk("hz_next_word", 64'(ld_hazard), 64'd0);
    ld_addr = 32'h0000_3000;
    mem_ready = 1'b1;
    tick();
    chk("hz_after_drain", 64'(ld_hazard), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
